// File: rtl/shift_pkg.sv
// Shared op codes and FSM encoding for the
// sequential shift/rotate unit.
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= OP_ROL;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of WIDTH bits by 0..STEP.
// Ports: i_op, i_a, i_s (amount) -> o_y.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SW-1:0]    i_s,
  output logic [WIDTH-1:0] o_y
);

  logic [31:0] w_s;

  always_comb begin
    w_s = 32'(i_s);
    o_y = i_a;
    case (i_op)
      OP_SHR:  o_y = i_a >> w_s;
      OP_SHRA: o_y = $unsigned($signed(i_a) >>> w_s);
      OP_SHL:  o_y = i_a << w_s;
      OP_ROR:  o_y = (i_a >> w_s)
                   | (i_a << (WIDTH - w_s));
      OP_ROL:  o_y = (i_a << w_s)
                   | (i_a >> (WIDTH - w_s));
      default: o_y = i_a;
    endcase
  end

endmodule

// File: rtl/shift_rot_unit.sv
// Multi-cycle shift/rotate unit, up to STEP bits/cycle.
// Ports: i_clk, i_clear, i_start, i_op, i_a, i_amt ->
//   o_result, o_busy, o_done, o_illegal.
module shift_rot_unit
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP   = 1,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int SW    = $clog2(STEP + 1)
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [AMT_W-1:0] i_amt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_illegal
);

  localparam logic [AMT_W:0] STEP_C =
    (AMT_W + 1)'(STEP);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_work;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_rem;
  logic             r_illegal;

  logic             w_accept;
  logic             w_legal;
  logic [AMT_W:0]   w_rem_ext;
  logic [AMT_W:0]   w_s_ext;
  logic [AMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_step_y;

  assign w_legal   = op_legal(i_op);
  assign w_accept  = i_start &&
                     (r_state == ST_IDLE ||
                      r_state == ST_DONE);
  assign w_rem_ext = {1'b0, r_rem};
  // Extra bit lets STEP == WIDTH compare cleanly.
  assign w_s_ext   = (w_rem_ext < STEP_C) ?
                     w_rem_ext : STEP_C;
  assign w_rem_next = r_rem - w_s_ext[AMT_W-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_op (r_op),
    .i_a  (r_work),
    .i_s  (w_s_ext[SW-1:0]),
    .o_y  (w_step_y)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_next = (w_legal && i_amt != '0) ?
                   ST_SHIFT : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_rem_next == '0) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_work    <= '0;
      r_op      <= OP_SHR;
      r_rem     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_work    <= i_a;
      r_op      <= i_op;
      // Illegal ops skip shifting entirely.
      r_rem     <= w_legal ? i_amt : '0;
      r_illegal <= !w_legal;
    end else if (r_state == ST_SHIFT) begin
      r_work    <= w_step_y;
      r_rem     <= w_rem_next;
    end else if (r_state == ST_DONE) begin
      r_illegal <= 1'b0;
    end
  end

  assign o_result  = r_work;
  assign o_busy    = (r_state == ST_SHIFT);
  assign o_done    = (r_state == ST_DONE);
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_shift_rot_unit.sv
// Directed bench for shift_rot_unit, STEP=1 and STEP=4
// instances driven with identical stimulus.
module tb_shift_rot_unit;

  logic        clk = 1'b0;
  logic        s_clear;
  logic        s_start;
  logic [2:0]  s_op;
  logic [31:0] s_a;
  logic [4:0]  s_amt;

  logic [31:0] res1, res4;
  logic        busy1, busy4;
  logic        done1, done4;
  logic        ill1, ill4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  shift_rot_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .i_clk     (clk),
    .i_clear   (s_clear),
    .i_start   (s_start),
    .i_op      (s_op),
    .i_a       (s_a),
    .i_amt     (s_amt),
    .o_result  (res1),
    .o_busy    (busy1),
    .o_done    (done1),
    .o_illegal (ill1)
  );

  shift_rot_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .i_clk     (clk),
    .i_clear   (s_clear),
    .i_start   (s_start),
    .i_op      (s_op),
    .i_a       (s_a),
    .i_amt     (s_amt),
    .o_result  (res4),
    .o_busy    (busy4),
    .o_done    (done4),
    .o_illegal (ill4)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic run(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [4:0]  amt,
    input logic [31:0] exp,
    input logic        exp_ill,
    input int          l1,
    input int          l4
  );
    int n, g1, g4, ov, b1;
    logic [31:0] r1, r4;
    logic i1, i4;
    n = 0; g1 = 0; g4 = 0; ov = 0; b1 = 0;
    r1 = '0; r4 = '0; i1 = 1'b0; i4 = 1'b0;
    @(negedge clk);
    s_op = op; s_a = a; s_amt = amt;
    s_start = 1'b1;
    while ((g1 == 0 || g4 == 0) && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s_start = 1'b0;
      if ((busy1 && done1) || (busy4 && done4)) ov++;
      if (busy1) b1++;
      if (done1 && g1 == 0) begin
        g1 = n; r1 = res1; i1 = ill1;
      end
      if (done4 && g4 == 0) begin
        g4 = n; r4 = res4; i4 = ill4;
      end
    end
    chk({tag, " lat1"}, g1, l1);
    chk({tag, " lat4"}, g4, l4);
    chk({tag, " res1"}, r1, exp);
    chk({tag, " res4"}, r4, exp);
    chk({tag, " ill1"}, 32'(i1), 32'(exp_ill));
    chk({tag, " ill4"}, 32'(i4), 32'(exp_ill));
    chk({tag, " ovl"}, ov, 0);
    chk({tag, " busy1"}, b1, (l1 > 0) ? l1 - 1 : 0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " res1"}, res1, 0);
    chk({tag, " res4"}, res4, 0);
    chk({tag, " bsy"}, 32'({busy1, busy4}), 0);
    chk({tag, " dn"}, 32'({done1, done4}), 0);
    chk({tag, " il"}, 32'({ill1, ill4}), 0);
  endtask

  initial begin
    int n, d1, d4, g;
    logic [31:0] p1 [2];
    logic [31:0] p4 [2];
    int t1 [2];
    int t4 [2];

    s_clear = 1'b1; s_start = 1'b0;
    s_op = 3'b000; s_a = '0; s_amt = '0;
    idle(3);
    chk_zero("reset");
    s_clear = 1'b0;

    run("rol1", 3'b100, 32'h8000_0001, 5'd1,
        32'h0000_0003, 1'b0, 2, 2);
    run("ror4", 3'b011, 32'h0000_0026, 5'd4,
        32'h6000_0002, 1'b0, 5, 2);
    run("shra31", 3'b001, 32'h8000_0000, 5'd31,
        32'hFFFF_FFFF, 1'b0, 32, 9);
    run("rol8", 3'b100, 32'h1234_5678, 5'd8,
        32'h3456_7812, 1'b0, 9, 3);
    run("amt0", 3'b010, 32'hA5A5_A5A5, 5'd0,
        32'hA5A5_A5A5, 1'b0, 1, 1);
    run("illop", 3'b110, 32'hDEAD_BEEF, 5'd5,
        32'hDEAD_BEEF, 1'b1, 1, 1);
    run("shr28", 3'b000, 32'hF000_0000, 5'd28,
        32'h0000_000F, 1'b0, 29, 8);
    run("shl31", 3'b010, 32'h0000_0001, 5'd31,
        32'h8000_0000, 1'b0, 32, 9);
    run("shrapos", 3'b001, 32'h7FFF_FFFF, 5'd3,
        32'h0FFF_FFFF, 1'b0, 4, 2);
    run("ror31", 3'b011, 32'h1234_5678, 5'd31,
        32'h2468_ACF0, 1'b0, 32, 9);
    run("shl5", 3'b010, 32'hFFFF_FFFF, 5'd5,
        32'hFFFF_FFE0, 1'b0, 6, 3);

    // start during SHIFT is ignored (STEP=1 unit)
    @(negedge clk);
    s_op = 3'b011; s_a = 32'h26; s_amt = 5'd4;
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_op = 3'b010; s_a = 32'hFFFF_FFFF;
    s_amt = 5'd1; s_start = 1'b1;
    n = 2; g = 0;
    while (g == 0 && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s_start = 1'b0;
      if (done1) begin
        g = n;
        chk("ign res1", res1, 32'h6000_0002);
      end
    end
    chk("ign lat1", g, 5);
    idle(40);

    // clear mid-SHIFT aborts; start with clear ignored
    @(negedge clk);
    s_op = 3'b001; s_a = 32'h8000_0000;
    s_amt = 5'd31; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    idle(4);
    s_clear = 1'b1;
    s_op = 3'b010; s_amt = 5'd0; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("clr");
    s_clear = 1'b0; s_start = 1'b0;
    d1 = 0; d4 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) d1++;
      if (done4) d4++;
    end
    chk("clr nodone1", d1, 0);
    chk("clr nodone4", d4, 0);

    // back-to-back with start held across DONE
    @(negedge clk);
    s_op = 3'b100; s_a = 32'h8000_0001;
    s_amt = 5'd1; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_op = 3'b000; s_a = 32'h0000_0100;
    s_amt = 5'd4;
    n = 1; d1 = 0; d4 = 0;
    p1[0] = '0; p1[1] = '0; p4[0] = '0; p4[1] = '0;
    t1[0] = 0; t1[1] = 0; t4[0] = 0; t4[1] = 0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 3) s_start = 1'b0;
      if (done1) begin
        if (d1 < 2) begin
          p1[d1] = res1; t1[d1] = n;
        end
        d1++;
      end
      if (done4) begin
        if (d4 < 2) begin
          p4[d4] = res4; t4[d4] = n;
        end
        d4++;
      end
    end
    chk("b2b cnt1", d1, 2);
    chk("b2b cnt4", d4, 2);
    chk("b2b r1a", p1[0], 32'h0000_0003);
    chk("b2b r1b", p1[1], 32'h0000_0010);
    chk("b2b r4a", p4[0], 32'h0000_0003);
    chk("b2b r4b", p4[1], 32'h0000_0010);
    chk("b2b t1a", t1[0], 2);
    chk("b2b t1b", t1[1], 7);
    chk("b2b t4b", t4[1], 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_rot_unit.md
SHIFT_ROT_UNIT -- requirements
Module: shift_rot_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>= 8).
REQ-002 Parameter STEP, default 1, max bit positions shifted per cycle (power of 2, 1..WIDTH).
REQ-003 Localparam AMT_W = clog2(WIDTH), width of shift amount.
REQ-004 The interface SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clock  input  1  system clock, all state updates on rising edge.
REQ-006 clear  input  1  synchronous active-high reset.
REQ-007 start  input  1  request pulse; sampled only when accepting (IDLE or DONE).
REQ-008 op  input  3  operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
REQ-009 a  input  WIDTH  operand, sampled with start.
REQ-010 amt  input  AMT_W  shift/rotate count, sampled with start.
REQ-011 result  output  WIDTH  registered result; valid while done=1 and held until next accepted start.
REQ-012 busy  output  1  high while operation in progress (SHIFT state).
REQ-013 done  output  1  registered single-cycle completion pulse.
REQ-014 illegal  output  1  registered; high with done when latched op was 101-111.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE/DONE with start=1: latch a into working register, op, amt into remaining counter; go to SHIFT if amt!=0 else DONE.
REQ-017 DONE with start=0: go to IDLE; done deasserts.
REQ-018 SHIFT: each cycle apply op by s = min(STEP, remaining) and decrement remaining by s; when remaining becomes 0 go to DONE.
REQ-019 Latency: done SHALL be high in the cycle following edge number ceil(amt/STEP)+1 counted from the start-sampling edge (amt=0: one edge).
REQ-020 start while in SHIFT SHALL be ignored; latched operands unchanged.
REQ-021 start in DONE SHALL be accepted (back-to-back); done deasserts next cycle.
REQ-022 SHR/SHL fill zeros; SHRA fills with latched a[WIDTH-1]; ROR/ROL wrap bits, no loss.
REQ-023 Result SHALL equal single-step combinational shift of a by amt for all amt 0..WIDTH-1, independent of STEP.
REQ-024 Illegal op: result = a unchanged, illegal=1 with done, same latency as amt=0 (amt ignored).
REQ-025 busy = (state==SHIFT); busy and done never high together.

Reset
REQ-026 clear=1 at a rising edge SHALL force IDLE, result=0, busy=0, done=0, illegal=0, remaining=0, regardless of state.
REQ-027 clear mid-SHIFT SHALL abort with no done pulse; start coincident with clear SHALL be ignored.

Structure
REQ-028 Package shift_pkg SHALL hold op-code constants and FSM state encoding.
REQ-029 One sub-module shift_step SHALL implement combinational shift/rotate of WIDTH bits by 0..STEP positions per op; shift_rot_unit instantiates it once.

Verification
REQ-030 ROL a=0x80000001 amt=1 STEP=1 -> result 0x00000003, done 2 edges after start, busy high 1 cycle.
REQ-031 ROR a=0x00000026 amt=4 STEP=1 -> result 0x60000002 after 5 edges; SHRA a=0x80000000 amt=31 -> 0xFFFFFFFF after 32 edges.
REQ-032 STEP=4: ROL a=0x12345678 amt=8 -> 0x34567812 after 3 edges; amt=0 any op -> result=a after 1 edge.
REQ-033 op=110 a=0xDEADBEEF -> result 0xDEADBEEF, illegal=1 with done after 1 edge.
REQ-034 start with new operands during SHIFT -> ignored, original result delivered; clear asserted mid-SHIFT -> no done, all outputs 0 next cycle.
REQ-035 start held high across DONE -> second operation accepted back-to-back, two distinct done pulses with correct results.
